nn_layer_engine: RTL and testbench
==================================

Name: nn_layer_engine

Overview:
- Parametrised, time-multiplexed fully-connected layer for the detection network. It generalises the fixed-topology detector to any neuron and input count, fixed-point width and run-time activation mode.
- NUM_NEURONS parallel MACs each consume one input per cycle. Per-neuron weight RAM is loaded over the same layer/neuron/weight-select write bus the detector uses.
- Several instances, with a sequencer, form the full detector.

Parameters:
- NUM_NEURONS, 4, neurons in layer (>=1)
- NUM_INPUTS, 100, inputs per neuron (>=1)
- DATA_W, 16, signed fixed-point input/output width
- WEIGHT_W, 16, signed fixed-point weight/bias width
- FRAC_BITS, 8, fractional bits shared by data and weights (< DATA_W)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  begin evaluation (pulse)
- act_sel  in  2  activation mode: 0 linear, 1 ReLU, 2 hard-tanh, 3 step
- data_in  in  NUM_INPUTS*DATA_W  packed inputs, element i at [i*DATA_W +: DATA_W]
- write_weight  in  1  weight write strobe
- neuron_sel  in  max(1,$clog2(NUM_NEURONS))  target neuron
- weight_sel  in  $clog2(NUM_INPUTS+1)  0 = bias, k = weight for input k-1
- weight_bus  in  WEIGHT_W  signed weight value
- data_out  out  NUM_NEURONS*DATA_W  packed activated outputs
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse
- weight_err  out  1  one-cycle pulse on a rejected write

Behaviour:
- Reset (rst_n low at posedge):
  - FSM goes to IDLE; data_out=0, busy=0, done=0, weight_err=0; accumulators and input latch cleared.
  - Weight RAM is NOT reset and retains its contents, so it infers as RAM.
- FSM states IDLE -> LOAD -> MAC -> ACT -> IDLE:
  - IDLE: start=1 moves to LOAD and sets busy=1. act_sel is latched.
  - LOAD (1 cycle): latches data_in; acc[n] = sign-extended bias[n] << FRAC_BITS; input index idx=0.
  - MAC (NUM_INPUTS cycles): acc[n] += data[idx]*w[n][idx+1], full-precision signed; idx increments; leave when idx==NUM_INPUTS-1.
  - ACT (1 cycle): computes each output and writes data_out; done=1 for this one cycle only; busy drops to 0 with done; next state IDLE.
- Accumulator width: ACC_W = DATA_W+WEIGHT_W+$clog2(NUM_INPUTS+1)+1, so it never overflows.
- Rescale: arithmetic shift right by FRAC_BITS (truncation toward -inf), then saturate to the signed DATA_W range.
- Activation, applied to the saturated value v:
  - linear: v
  - ReLU: max(v,0)
  - hard-tanh: clamp(v, -(1<<FRAC_BITS), 1<<FRAC_BITS)
  - step: (v>=0) ? (1<<FRAC_BITS) : 0
- Latency: done is high in cycle NUM_INPUTS+2 after the start-sampling edge. Minimum start-to-start interval is NUM_INPUTS+2 cycles; start may reassert in the cycle after done.
- data_out holds its value until the next ACT or reset.
- start while busy is ignored.
- Weight writes:
  - Accepted in IDLE only; take effect at the posedge.
  - Rejected, with weight_err pulsed for one cycle and RAM unchanged, if any of these holds: busy; neuron_sel >= NUM_NEURONS; weight_sel > NUM_INPUTS.
- start and write_weight in the same IDLE cycle: the write is applied and the evaluation uses the new weight.
- Reset mid-operation: evaluation is aborted, no done is issued, and a subsequent start yields correct results.

Optional Feature:
- Macro: NN_LAYER_ROUND_EN.
- Defined: rescale adds 1<<(FRAC_BITS-1) to acc before the arithmetic shift (round half up), then saturates.
- Undefined: plain truncating shift.
- Latency is identical in both builds.

Test Plan:
Common setup: NUM_NEURONS=2, NUM_INPUTS=3, DATA_W=WEIGHT_W=16, FRAC_BITS=8.
- Basic: n0 bias 0, weights 256/256/256; n1 bias -1024, weights 256/256/256; inputs 256,512,-256; act_sel=0 -> done exactly 5 cycles after start; n0=512, n1=-512; busy high 5 cycles.
- Activations, same setup:
  - act_sel=1 -> n0=512, n1=0
  - act_sel=2 -> n0=256, n1=-256
  - act_sel=3 -> n0=256, n1=0
- Saturation: all weights 32767, inputs 32767, bias 32767 -> n0=32767; all inputs -32768 with weights 32767 -> -32768.
- Rounding: bias 0, weight1=1, other weights 0, input0=128 -> output 0 without NN_LAYER_ROUND_EN, 1 with it.
- Write errors:
  - write neuron_sel=2 -> weight_err pulse.
  - write weight_sel=4 -> weight_err pulse.
  - write during MAC -> weight_err pulse.
  - In all three cases a rerun of Basic still gives 512/-512.
- Reset/overlap: rst_n low for 1 cycle during MAC -> outputs 0, no done; restart gives Basic results (weights retained). start pulsed while busy -> ignored, exactly one done.

Source files
------------

// File: rtl/nn_layer_engine.sv
// Time-multiplexed fully-connected layer: NUM_NEURONS MACs with per-neuron weight RAM.
// Build option NN_LAYER_ROUND_EN: round half up on rescale instead of truncating.
module nn_layer_engine #(
   parameter int unsigned NUM_NEURONS = 4,
   parameter int unsigned NUM_INPUTS  = 100,
   parameter int unsigned DATA_W      = 16,
   parameter int unsigned WEIGHT_W    = 16,
   parameter int unsigned FRAC_BITS   = 8,
   localparam int unsigned NSEL_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int unsigned WSEL_W = $clog2(NUM_INPUTS + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [1:0]                    act_sel,
   input  logic [NUM_INPUTS*DATA_W-1:0]  data_in,
   input  logic                          write_weight,
   input  logic [NSEL_W-1:0]             neuron_sel,
   input  logic [WSEL_W-1:0]             weight_sel,
   input  logic [WEIGHT_W-1:0]           weight_bus,
   output logic [NUM_NEURONS*DATA_W-1:0] data_out,
   output logic                          busy,
   output logic                          done,
   output logic                          weight_err
);

   localparam int unsigned ACC_W  = DATA_W + WEIGHT_W + $clog2(NUM_INPUTS + 1) + 1;
   localparam int unsigned IDX_W  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
   localparam int unsigned PROD_W = DATA_W + WEIGHT_W;

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] OUT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W-1:0] OUT_MIN = {1'b1, {(DATA_W-1){1'b0}}};
   localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_BITS;
   localparam logic signed [DATA_W-1:0] NEG_ONE = -ONE;
`ifdef NN_LAYER_ROUND_EN
   localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (FRAC_BITS - 1);
`endif

   typedef enum logic [1:0] {StIdle, StLoad, StMac, StAct} state_e;

   state_e                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [1:0]                  act_q, act_d;
   logic [NUM_INPUTS*DATA_W-1:0] data_q, data_d;
   logic signed [ACC_W-1:0]     acc_q [NUM_NEURONS];
   logic signed [ACC_W-1:0]     acc_d [NUM_NEURONS];
   logic signed [DATA_W-1:0]    out_q [NUM_NEURONS];
   logic signed [DATA_W-1:0]    out_d [NUM_NEURONS];
   logic signed [PROD_W-1:0]    prod  [NUM_NEURONS];
   logic signed [WEIGHT_W-1:0]  wmem  [NUM_NEURONS][NUM_INPUTS+1];
   logic signed [DATA_W-1:0]    x_cur;
   logic [WSEL_W-1:0]           widx;
   logic                        err_q, wr_bad, wr_ok;

   // Rescale, saturate, then apply the latched activation mode.
   function automatic logic signed [DATA_W-1:0] activate(input logic signed [ACC_W-1:0] acc,
                                                         input logic [1:0] sel);
      logic signed [ACC_W-1:0]  r;
      logic signed [ACC_W-1:0]  s;
      logic signed [DATA_W-1:0] v;
      logic signed [DATA_W-1:0] y;
      r = acc;
`ifdef NN_LAYER_ROUND_EN
      r = acc + RND;
`endif
      s = r >>> FRAC_BITS;
      if (s > SAT_MAX) begin
         v = OUT_MAX;
      end else if (s < SAT_MIN) begin
         v = OUT_MIN;
      end else begin
         v = s[DATA_W-1:0];
      end
      case (sel)
         2'd0:    y = v;
         2'd1:    y = v[DATA_W-1] ? '0 : v;
         2'd2:    y = (v > ONE) ? ONE : ((v < NEG_ONE) ? NEG_ONE : v);
         default: y = v[DATA_W-1] ? '0 : ONE;
      endcase
      return y;
   endfunction

   assign busy       = (state_q != StIdle);
   assign done       = (state_q == StAct);
   assign weight_err = err_q;

   assign wr_bad = busy | (32'(neuron_sel) >= NUM_NEURONS) | (32'(weight_sel) > NUM_INPUTS);
   assign wr_ok  = write_weight & rst_n & ~wr_bad;

   // No reset on the weight store so it maps onto RAM and survives a reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         wmem[neuron_sel][weight_sel] <= weight_bus;
      end
   end

   assign x_cur = $signed(data_q[int'(idx_q)*DATA_W +: DATA_W]);
   assign widx  = WSEL_W'(idx_q) + WSEL_W'(1);

   always_comb begin
      for (int n = 0; n < int'(NUM_NEURONS); n++) begin
         prod[n] = PROD_W'(x_cur) * PROD_W'(wmem[n][widx]);
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      act_d   = act_q;
      data_d  = data_q;
      acc_d   = acc_q;
      out_d   = out_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StLoad;
               act_d   = act_sel;
            end
         end
         StLoad: begin
            data_d = data_in;
            idx_d  = '0;
            for (int n = 0; n < int'(NUM_NEURONS); n++) begin
               acc_d[n] = (ACC_W'(wmem[n][0])) <<< FRAC_BITS;
            end
            state_d = StMac;
         end
         StMac: begin
            for (int n = 0; n < int'(NUM_NEURONS); n++) begin
               acc_d[n] = acc_q[n] + ACC_W'(prod[n]);
            end
            idx_d = idx_q + IDX_W'(1);
            // Register outputs on the final MAC so they are valid alongside done.
            if (idx_q == IDX_W'(NUM_INPUTS - 1)) begin
               state_d = StAct;
               for (int n = 0; n < int'(NUM_NEURONS); n++) begin
                  out_d[n] = activate(acc_d[n], act_q);
               end
            end
         end
         StAct: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         act_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         for (int n = 0; n < int'(NUM_NEURONS); n++) begin
            acc_q[n] <= '0;
            out_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         act_q   <= act_d;
         data_q  <= data_d;
         err_q   <= write_weight & wr_bad;
         for (int n = 0; n < int'(NUM_NEURONS); n++) begin
            acc_q[n] <= acc_d[n];
            out_q[n] <= out_d[n];
         end
      end
   end

   for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_out
      assign data_out[g*DATA_W +: DATA_W] = out_q[g];
   end

endmodule

// File: tb/tb_nn_layer_engine.sv
// Bench for nn_layer_engine: arithmetic reference model with per-cycle compare plus
// directed literal checks. A second small instance exercises out-of-range write selects.
`timescale 1ns/1ps
module tb_nn_layer_engine;
   localparam int NN = 2;
   localparam int NI = 3;
   localparam int DW = 16;
`ifdef NN_LAYER_ROUND_EN
   localparam int RND_EXP = 1;
`else
   localparam int RND_EXP = 0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start = 1'b0;
   logic [1:0]     act_sel = 2'd0;
   logic [NI*DW-1:0] data_in = '0;
   logic           write_weight = 1'b0;
   logic [0:0]     neuron_sel = '0;
   logic [1:0]     weight_sel = '0;
   logic [15:0]    weight_bus = '0;
   logic [NN*DW-1:0] data_out;
   logic           busy, done, weight_err;

   logic           a_wr = 1'b0;
   logic [1:0]     a_nsel = '0;
   logic [2:0]     a_wsel = '0;
   logic [15:0]    a_bus = '0;
   logic [4*DW-1:0] a_din = '0;
   logic [3*DW-1:0] a_dout;
   logic           a_busy, a_done, a_err;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   nn_layer_engine #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .DATA_W(DW), .WEIGHT_W(16),
                     .FRAC_BITS(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .act_sel(act_sel), .data_in(data_in),
      .write_weight(write_weight), .neuron_sel(neuron_sel), .weight_sel(weight_sel),
      .weight_bus(weight_bus), .data_out(data_out), .busy(busy), .done(done),
      .weight_err(weight_err)
   );

   nn_layer_engine #(.NUM_NEURONS(3), .NUM_INPUTS(4), .DATA_W(DW), .WEIGHT_W(16),
                     .FRAC_BITS(8)) u_aux (
      .clk(clk), .rst_n(rst_n), .start(1'b0), .act_sel(2'd0), .data_in(a_din),
      .write_weight(a_wr), .neuron_sel(a_nsel), .weight_sel(a_wsel), .weight_bus(a_bus),
      .data_out(a_dout), .busy(a_busy), .done(a_done), .weight_err(a_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic signed [63:0] got,
                      input logic signed [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
      end
   endtask

   // Reference model: weights, latched inputs, cycles left in the current evaluation.
   int mw [NN][NI+1];
   int md [NI];
   int pend [NN];
   int exp_d [NN];
   int cnt = 0;
   bit exp_err = 1'b0;

   function automatic int model_out(input int n, input int act);
      longint s, q;
      int v;
      s = longint'(mw[n][0]) * 256;
      for (int i = 0; i < NI; i++) s += longint'(md[i]) * longint'(mw[n][i+1]);
      s += 128 * RND_EXP;
      q = s / 256;
      if ((s % 256 != 0) && (s < 0)) q -= 1;
      if (q > 32767) q = 32767;
      if (q < -32768) q = -32768;
      v = int'(q);
      case (act)
         0: return v;
         1: return (v < 0) ? 0 : v;
         2: return (v > 256) ? 256 : ((v < -256) ? -256 : v);
         default: return (v >= 0) ? 256 : 0;
      endcase
   endfunction

   initial for (int n = 0; n < NN; n++) exp_d[n] = 0;

   always @(posedge clk) begin
      if (!rst_n) begin
         cnt = 0;
         exp_err = 1'b0;
         for (int n = 0; n < NN; n++) exp_d[n] = 0;
      end else begin
         exp_err = write_weight && (cnt != 0 || int'(neuron_sel) >= NN || int'(weight_sel) > NI);
         if (write_weight && !exp_err) mw[neuron_sel][weight_sel] = int'($signed(weight_bus));
         if (cnt != 0) begin
            cnt--;
            if (cnt == 1) for (int n = 0; n < NN; n++) exp_d[n] = pend[n];
         end else if (start) begin
            for (int i = 0; i < NI; i++) md[i] = int'($signed(data_in[i*DW +: DW]));
            for (int n = 0; n < NN; n++) pend[n] = model_out(n, int'(act_sel));
            cnt = NI + 2;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("busy", busy, cnt != 0);
         chk("done", done, cnt == 1);
         chk("weight_err", weight_err, exp_err);
         for (int n = 0; n < NN; n++) chk("data_out", $signed(data_out[n*DW +: DW]), exp_d[n]);
      end
   end

   task automatic wr(input int n, input int k, input int v);
      @(negedge clk);
      write_weight = 1'b1;
      neuron_sel = 1'(n);
      weight_sel = 2'(k);
      weight_bus = 16'(v);
      @(negedge clk);
      write_weight = 1'b0;
   endtask

   task automatic set_in(input int a, input int b, input int c);
      data_in[0 +: DW]    = 16'(a);
      data_in[DW +: DW]   = 16'(b);
      data_in[2*DW +: DW] = 16'(c);
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic run_chk(input string tag, input int act, input int e0, input int e1);
      int lat;
      @(negedge clk);
      act_sel = 2'(act);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      chk({tag, " latency"}, lat, NI + 2);
      chk({tag, " n0"}, $signed(data_out[0 +: DW]), e0);
      chk({tag, " n1"}, $signed(data_out[DW +: DW]), e1);
      @(negedge clk);
      chk({tag, " busy after done"}, busy, 0);
   endtask

   task automatic load_basic();
      wr(0, 0, 0);
      wr(1, 0, -1024);
      for (int k = 1; k <= NI; k++) begin
         wr(0, k, 256);
         wr(1, k, 256);
      end
      set_in(256, 512, -256);
   endtask

   task automatic aux_wr(input string tag, input int n, input int k, input int want);
      @(negedge clk);
      a_wr = 1'b1;
      a_nsel = 2'(n);
      a_wsel = 3'(k);
      a_bus = 16'h1234;
      @(negedge clk);
      a_wr = 1'b0;
      chk(tag, a_err, want);
      @(negedge clk);
      chk({tag, " clear"}, a_err, 0);
   endtask

   initial begin
      int lat, dn;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset weight_err", weight_err, 0);
      chk("reset data_out", data_out, 0);
      cmp_en = 1'b1;

      load_basic();
      run_chk("basic linear", 0, 512, -512);
      run_chk("relu", 1, 512, 0);
      run_chk("hardtanh", 2, 256, -256);
      run_chk("step", 3, 256, 0);

      for (int n = 0; n < NN; n++) for (int k = 0; k <= NI; k++) wr(n, k, 32767);
      set_in(32767, 32767, 32767);
      run_chk("sat pos", 0, 32767, 32767);
      set_in(-32768, -32768, -32768);
      run_chk("sat neg", 0, -32768, -32768);

      for (int n = 0; n < NN; n++) begin
         wr(n, 0, 0);
         wr(n, 1, 1);
         wr(n, 2, 0);
         wr(n, 3, 0);
      end
      set_in(128, 0, 0);
      run_chk("rounding", 0, RND_EXP, RND_EXP);

      aux_wr("err neuron_sel range", 3, 0, 1);
      aux_wr("err weight_sel range", 0, 5, 1);
      aux_wr("ok write top index", 2, 4, 0);

      load_basic();
      @(negedge clk);
      act_sel = 2'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      write_weight = 1'b1;
      neuron_sel = 1'b0;
      weight_sel = 2'd1;
      weight_bus = 16'd999;
      @(negedge clk);
      write_weight = 1'b0;
      chk("err write while busy", weight_err, 1);
      wait_done(lat);
      chk("busy write ignored n0", $signed(data_out[0 +: DW]), 512);
      @(negedge clk);
      run_chk("rerun after errors", 0, 512, -512);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("abort data_out", data_out, 0);
      chk("abort busy", busy, 0);
      dn = 0;
      repeat (8) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
      end
      chk("abort no done", dn, 0);
      run_chk("restart after reset", 0, 512, -512);

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dn = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) dn++;
      end
      chk("start while busy one done", dn, 1);

      @(negedge clk);
      act_sel = 2'd0;
      start = 1'b1;
      write_weight = 1'b1;
      neuron_sel = 1'b0;
      weight_sel = 2'd0;
      weight_bus = 16'd256;
      @(negedge clk);
      start = 1'b0;
      write_weight = 1'b0;
      wait_done(lat);
      chk("start+write latency", lat, NI + 2);
      chk("start+write n0", $signed(data_out[0 +: DW]), 768);
      chk("start+write n1", $signed(data_out[DW +: DW]), -512);
      repeat (2) @(negedge clk);

      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout got 0 expected 1");
      $fatal(1, "watchdog");
   end

endmodule
